// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the RAM arbiter slice.
// Defaults match the 4096 x 8 RAM shared by four client engines.
package ram_arb_pkg;

  localparam int DATAWID_DEF  = 8;
  localparam int ADDERWID_DEF = 12;
  localparam int NREQ_DEF     = 4;

  function automatic int idw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                          valid;
    logic [idw_of(NREQ_DEF)-1:0]   id;
    logic [DATAWID_DEF-1:0]        data;
  } rsp_rec_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin single-grant arbiter; owns the priority pointer.
// Scan starts at the pointer and wraps explicitly for any NREQ.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = idw_of(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);

  logic [IDW-1:0] ptr;

  always_comb begin
    int idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (advance && gnt_any)
      ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM among NREQ requesters.
// Reads answer one cycle after grant, tagged with the requester ID.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int DATAWID  = DATAWID_DEF,
  parameter  int ADDERWID = ADDERWID_DEF,
  parameter  int NREQ     = NREQ_DEF,
  localparam int IDW      = idw_of(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDERWID-1:0] req_addr,
  input  logic [NREQ*DATAWID-1:0]  req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [DATAWID-1:0]       rsp_data,
  output logic                     ram_we,
  output logic [ADDERWID-1:0]      ram_addr,
  output logic [DATAWID-1:0]       ram_din,
  input  logic [DATAWID-1:0]       ram_dout
);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } rsp_hdr_t;

  logic [NREQ-1:0] req_live;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic            gnt_rd;
  rsp_hdr_t        rsp_q;

  // Masking at the source keeps reset cycles grant-free.
  assign req_live = reset ? '0 : req_valid;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req_live),
    .advance (gnt_any),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;
  assign gnt_rd    = gnt_any & ~req_we[gnt_id];

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt_any) begin
      ram_we   = req_we[gnt_id];
      ram_addr = req_addr[int'(gnt_id)*ADDERWID +: ADDERWID];
      ram_din  = req_wdata[int'(gnt_id)*DATAWID +: DATAWID];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q.valid <= 1'b0;
      rsp_q.id    <= '0;
    end else begin
      rsp_q.valid <= gnt_rd;
      if (gnt_rd) rsp_q.id <= gnt_id;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_q.valid) rsp_valid[rsp_q.id] = 1'b1;
  end

  assign rsp_id   = rsp_q.id;
  assign rsp_data = ram_dout;

endmodule
